// File: rtl/jogo_pkg.sv
// Shared definitions for the game input path and control unit:
// FSM state codes, default timing parameters and a one-hot helper.
package jogo_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int TIMEOUT_CYCLES_DEF  = 5000;

    typedef enum logic [3:0] {
        ESPERA   = 4'd0,
        FILTRA   = 4'd1,
        REGISTRA = 4'd2,
        SEGURA   = 4'd3,
        INVALIDA = 4'd4
    } estado_t;

    function automatic logic one_hot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/detector_jogada_if.sv
// Switch inputs, timeout control and conditioned play outputs of detector_jogada.
interface detector_jogada_if;

    logic [3:0] chaves;
    logic       conta_timeout;
    logic       zera_timeout;
    logic [3:0] jogada;
    logic       jogada_feita;
    logic       tem_jogada;
    logic       timeout;
    logic [3:0] db_estado;

    modport master (
        output chaves, conta_timeout, zera_timeout,
        input  jogada, jogada_feita, tem_jogada, timeout, db_estado
    );

    modport slave (
        input  chaves, conta_timeout, zera_timeout,
        output jogada, jogada_feita, tem_jogada, timeout, db_estado
    );

endinterface

// File: rtl/contador_timeout.sv
// Per-play timeout counter with sticky flag; present only when
// DETECTOR_JOGADA_TIMEOUT_EN is defined.
`ifdef DETECTOR_JOGADA_TIMEOUT_EN
module contador_timeout
    import jogo_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic conta,
    input  logic zera,
    input  logic jogada_feita,
    output logic timeout
);

    localparam int              W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0]    FIM = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    // A play landing on the terminal count wins: counter restarts, flag stays low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else if (zera) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else if (jogada_feita) begin
            cnt <= '0;
        end else if (conta && !timeout) begin
            if (cnt == FIM) timeout <= 1'b1;
            else            cnt     <= cnt + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/detector_jogada.sv
// Switch synchronizer, debouncer and one-hot press detector with optional
// play timeout (compiled in when DETECTOR_JOGADA_TIMEOUT_EN is defined).
//
// state    | meaning
// ESPERA   | all keys released
// FILTRA   | keys seen, waiting for a stable value
// REGISTRA | single key accepted, one-cycle strobe
// SEGURA   | accepted key held, waiting for debounced release
// INVALIDA | several keys pressed, waiting for debounced release
module detector_jogada
    import jogo_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
    input  logic               clock,
    input  logic               reset,
    detector_jogada_if.slave   bus
);

    localparam int              CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   FIM_DB = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    sync_1, s_chaves, s_chaves_q;
    logic [CW-1:0] cnt;
    logic [3:0]    jogada_r;
    logic          estavel, cnt_fim, jogada_feita;
    estado_t       estado, prox;

    assign estavel = (s_chaves == s_chaves_q);
    assign cnt_fim = (cnt == FIM_DB);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_1     <= '0;
            s_chaves   <= '0;
            s_chaves_q <= '0;
        end else begin
            sync_1     <= bus.chaves;
            s_chaves   <= sync_1;
            s_chaves_q <= s_chaves;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= ESPERA;
        else        estado <= prox;
    end

    // Saturates at the terminal value so a long hold cannot wrap it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                          cnt <= '0;
        else if (prox != estado || !estavel) cnt <= '0;
        else if (!cnt_fim)                   cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                                    jogada_r <= '0;
        else if (estado == FILTRA && prox == REGISTRA) jogada_r <= s_chaves;
    end

    always_comb begin
        prox = estado;
        case (estado)
            ESPERA:   if (s_chaves != 4'b0000) prox = FILTRA;
            FILTRA: begin
                if (s_chaves == 4'b0000)       prox = ESPERA;
                else if (estavel && cnt_fim)   prox = one_hot(s_chaves) ? REGISTRA : INVALIDA;
            end
            REGISTRA: prox = SEGURA;
            SEGURA, INVALIDA:
                if (s_chaves == 4'b0000 && estavel && cnt_fim) prox = ESPERA;
            default:  prox = ESPERA;
        endcase
    end

    assign jogada_feita     = (estado == REGISTRA);
    assign bus.jogada_feita = jogada_feita;
    assign bus.tem_jogada   = (estado == REGISTRA) || (estado == SEGURA);
    assign bus.jogada       = jogada_r;
    assign bus.db_estado    = estado;

`ifdef DETECTOR_JOGADA_TIMEOUT_EN
    contador_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_contador_timeout (
        .clock        (clock),
        .reset        (reset),
        .conta        (bus.conta_timeout),
        .zera         (bus.zera_timeout),
        .jogada_feita (jogada_feita),
        .timeout      (bus.timeout)
    );
`else
    logic unused_timeout;
    assign unused_timeout = bus.conta_timeout | bus.zera_timeout | (TIMEOUT_CYCLES < 2);
    assign bus.timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_detector_jogada.sv
// Self-checking bench for detector_jogada: table of presses plus hand-written
// bounce, reset and timeout sequences; strobes are matched against a queue.
module tb_detector_jogada;

    localparam int D = 4;
    localparam int T = 10;

    logic clock = 1'b0;
    logic reset = 1'b0;

    detector_jogada_if bus();

    detector_jogada #(
        .DEBOUNCE_CYCLES (D),
        .TIMEOUT_CYCLES  (T)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_tests   = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int n_strobes = 0;

    typedef struct {
        logic [3:0] jogada;
        int         ciclo;
    } esp_t;
    esp_t fila[$];

    typedef struct {
        logic [3:0] chaves;
        logic       valida;
        logic [3:0] jogada;
    } vec_t;
    vec_t vetores[7];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_tests++;
        if (atual !== esperado) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nome, atual, esperado, cyc);
        end
    endtask

    // Every strobe must match the oldest expected press, value and cycle.
    always @(negedge clock) begin
        if (reset && bus.jogada_feita === 1'b1) begin
            n_strobes++;
            if (fila.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL strobe_extra: got strobe with jogada=0x%0h, expected none (cycle %0d)", bus.jogada, cyc);
            end else begin
                esp_t e;
                e = fila.pop_front();
                check("strobe_jogada", bus.jogada, e.jogada);
                check("strobe_ciclo", cyc, e.ciclo);
                check("strobe_tem_jogada", bus.tem_jogada, 1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "time limit");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic espera_repouso(input string nome);
        int i = 0;
        while (bus.db_estado !== 4'd0 && i < 40) begin
            tick(1);
            i++;
        end
        check(nome, bus.db_estado, 0);
    endtask

    function automatic int estado_seq(input int i);
        if (i <= 2)     return 0;
        if (i <= D + 2) return 1;
        if (i == D + 3) return 2;
        return 3;
    endfunction

    task automatic aplica(input vec_t v);
        bus.chaves = v.chaves;
        if (v.valida) fila.push_back('{v.chaves, cyc + D + 3});
        tick(D + 8);
        check("estado_pressionado", bus.db_estado, v.valida ? 3 : 4);
        check("tem_jogada", bus.tem_jogada, v.valida);
        check("jogada_valor", bus.jogada, v.jogada);
        bus.chaves = 4'b0000;
        espera_repouso("retorno_espera");
        check("jogada_retida", bus.jogada, v.jogada);
        check("fila_vazia", fila.size(), 0);
        tick(2);
    endtask

    initial begin
        int s0;
        vetores[0] = '{4'b0001, 1'b1, 4'b0001};
        vetores[1] = '{4'b0110, 1'b0, 4'b0001};
        vetores[2] = '{4'b1000, 1'b1, 4'b1000};
        vetores[3] = '{4'b1111, 1'b0, 4'b1000};
        vetores[4] = '{4'b0010, 1'b1, 4'b0010};
        vetores[5] = '{4'b1010, 1'b0, 4'b0010};
        vetores[6] = '{4'b0100, 1'b1, 4'b0100};

        bus.chaves        = 4'b0000;
        bus.conta_timeout = 1'b0;
        bus.zera_timeout  = 1'b0;
        tick(3);
        check("reset_jogada", bus.jogada, 0);
        check("reset_feita", bus.jogada_feita, 0);
        check("reset_tem", bus.tem_jogada, 0);
        check("reset_timeout", bus.timeout, 0);
        check("reset_estado", bus.db_estado, 0);
        reset = 1'b1;
        tick(2);

        // First press: state trace 0,0,1..1,2,3 and a held-key bounce in SEGURA.
        bus.chaves = 4'b0100;
        fila.push_back('{4'b0100, cyc + D + 3});
        for (int i = 1; i <= D + 4; i++) begin
            tick(1);
            check("seq_estado", bus.db_estado, estado_seq(i));
        end
        check("seq_jogada", bus.jogada, 4'b0100);
        bus.chaves = 4'b0000;
        tick(2);
        bus.chaves = 4'b0100;
        tick(3);
        check("segura_rebote", bus.db_estado, 3);
        bus.chaves = 4'b0000;
        espera_repouso("seq_retorno");
        check("seq_strobe_unico", n_strobes, 1);
        tick(2);

        for (int i = 0; i < 7; i++) aplica(vetores[i]);

        // Bouncing press: only the final stable level yields a strobe.
        s0 = n_strobes;
        for (int i = 0; i < 10; i++) begin
            bus.chaves = ((i / 2) % 2 == 1) ? 4'b0100 : 4'b0000;
            tick(1);
        end
        bus.chaves = 4'b0100;
        fila.push_back('{4'b0100, cyc + D + 3});
        tick(D + 30);
        check("rebote_estado", bus.db_estado, 3);
        bus.chaves = 4'b0000;
        espera_repouso("rebote_retorno");
        check("rebote_strobes", n_strobes - s0, 1);
        check("rebote_fila", fila.size(), 0);
        tick(2);

        // Reset while a key is held, then the same key counts as a new press.
        bus.chaves = 4'b0001;
        fila.push_back('{4'b0001, cyc + D + 3});
        tick(D + 8);
        check("pre_reset_estado", bus.db_estado, 3);
        reset = 1'b0;
        #1;
        check("rst_meio_jogada", bus.jogada, 0);
        check("rst_meio_feita", bus.jogada_feita, 0);
        check("rst_meio_tem", bus.tem_jogada, 0);
        check("rst_meio_estado", bus.db_estado, 0);
        tick(3);
        reset = 1'b1;
        fila.push_back('{4'b0001, cyc + D + 3});
        tick(D + 8);
        check("pos_reset_estado", bus.db_estado, 3);
        check("pos_reset_jogada", bus.jogada, 4'b0001);
        bus.chaves = 4'b0000;
        espera_repouso("pos_reset_retorno");
        check("pos_reset_fila", fila.size(), 0);
        tick(2);

`ifdef DETECTOR_JOGADA_TIMEOUT_EN
        bus.zera_timeout = 1'b1;
        tick(1);
        bus.zera_timeout  = 1'b0;
        bus.conta_timeout = 1'b1;
        tick(T - 1);
        check("to_antes", bus.timeout, 0);
        tick(1);
        check("to_fim", bus.timeout, 1);
        tick(5);
        check("to_pegajoso", bus.timeout, 1);
        bus.zera_timeout = 1'b1;
        tick(1);
        check("to_zera", bus.timeout, 0);
        bus.conta_timeout = 1'b0;
        tick(1);
        bus.zera_timeout  = 1'b0;
        bus.conta_timeout = 1'b1;
        tick(T - 1 - (D + 3));
        bus.chaves = 4'b1000;
        fila.push_back('{4'b1000, cyc + D + 3});
        tick(D + 4);
        check("to_press_fim", bus.timeout, 0);
        tick(T - 1);
        check("to_reinicio_antes", bus.timeout, 0);
        tick(1);
        check("to_reinicio_fim", bus.timeout, 1);
        bus.conta_timeout = 1'b0;
        bus.zera_timeout  = 1'b1;
        tick(1);
        bus.zera_timeout = 1'b0;
        check("to_zera_final", bus.timeout, 0);
        bus.chaves = 4'b0000;
        espera_repouso("to_retorno");
        check("to_fila", fila.size(), 0);
`else
        bus.conta_timeout = 1'b1;
        tick(T + 5);
        check("to_desligado", bus.timeout, 0);
        bus.zera_timeout = 1'b1;
        tick(1);
        bus.zera_timeout  = 1'b0;
        bus.conta_timeout = 1'b0;
        check("to_desligado_zera", bus.timeout, 0);
`endif

        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
